// File: rtl/tt_um_sar_probe_ctrl.sv
// Successive-approximation probe controller: drives probe B to an external X<B comparator
// and resolves X MSB-first, holding the result with a done flag.
module tt_um_sar_probe_ctrl #(
    parameter int WIDTH  = 7,
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0]       SETTLE_CNT = 4'(SETTLE);
    localparam logic [WIDTH-1:0] MSB_MASK   = WIDTH'(1) << (WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] probe_q, probe_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             start_q, start_d;

    logic             start_rise, abort, cmp_lt;
    logic [WIDTH-1:0] next_res;
    logic             unused_ok;

    assign start_rise = ui_in[0] & ~start_q;
    assign abort      = ui_in[1];
    assign cmp_lt     = ui_in[7];
    // cmp_lt=0 means X >= probe, so the bit under test belongs in X
    assign next_res   = cmp_lt ? result_q : (result_q | mask_q);
    assign unused_ok  = &{1'b0, ena, uio_in, ui_in[6:2]};

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        probe_d  = probe_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        start_d  = ui_in[0];
        case (state_q)
            IDLE, DONE: begin
                if (abort) begin
                    state_d  = IDLE;
                    result_d = '0;
                    probe_d  = '0;
                end else if (start_rise) begin
                    state_d  = WAIT;
                    result_d = '0;
                    mask_d   = MSB_MASK;
                    probe_d  = MSB_MASK;
                    cnt_d    = SETTLE_CNT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d  = IDLE;
                    result_d = '0;
                    probe_d  = '0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    result_d = next_res;
                    if (mask_q == WIDTH'(1)) begin
                        probe_d = next_res;
                        state_d = DONE;
                    end else begin
                        mask_d  = mask_q >> 1;
                        probe_d = next_res | (mask_q >> 1);
                        cnt_d   = SETTLE_CNT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            probe_q  <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            probe_q  <= probe_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
        end
    end

    // Outputs come straight from flops; done/busy decode the registered state only.
    always_comb begin
        uo_out             = '0;
        uo_out[WIDTH-1:0]  = result_q;
        uo_out[7]          = (state_q == DONE);
        uio_out            = '0;
        uio_out[WIDTH-1:0] = probe_q;
        uio_out[7]         = (state_q == WAIT);
    end

    assign uio_oe = 8'hFF;
endmodule

// File: tb/tb_tt_um_sar_probe_ctrl.sv
// Loop-back bench: two controllers (SETTLE=2 and SETTLE=0) each see a comparator model X < probe.
module tb_tt_um_sar_probe_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort;
    logic [6:0] x;
    logic       noise, noise0, glitch_en;
    logic [7:0] ui_in, ui_in0;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [7:0] uo0, uio0, oe0;
    int         n_cmp = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    assign ui_in  = {(x < uio_out[6:0]) ^ noise, 5'b0, abort, start};
    assign ui_in0 = {(x < uio0[6:0]) ^ noise0, 5'b0, abort, start};

    tt_um_sar_probe_ctrl #(.WIDTH(7), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(8'h00), .uio_out(uio_out), .uio_oe(uio_oe));

    tt_um_sar_probe_ctrl #(.WIDTH(7), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_in0), .uo_out(uo0),
        .uio_in(8'h00), .uio_out(uio0), .uio_oe(oe0));

    // Glitch the SETTLE=0 comparator line mid-cycle; it is clean again before every edge.
    initial begin
        noise0 = 1'b0;
        forever begin
            @(posedge clk);
            #1 noise0 = glitch_en;
            #5 noise0 = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_conv(input logic [6:0] xv, output int lat, output int lat0);
        x = xv;
        pulse_start();
        lat  = -1;
        lat0 = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (lat0 < 0 && uo0[7]) lat0 = c;
            if (lat < 0 && uo_out[7]) lat = c;
            if (lat >= 0 && lat0 >= 0) break;
        end
    endtask

    typedef struct {
        logic [6:0] x;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;

    vec_t       vecs[7];
    logic [6:0] pseq[7];
    int         lat, lat0, busy_cnt;

    initial begin
        vecs[0] = '{7'h55, 8'hD5, 8'h55};
        vecs[1] = '{7'h00, 8'h80, 8'h00};
        vecs[2] = '{7'h7F, 8'hFF, 8'h7F};
        vecs[3] = '{7'h2A, 8'hAA, 8'h2A};
        vecs[4] = '{7'h01, 8'h81, 8'h01};
        vecs[5] = '{7'h40, 8'hC0, 8'h40};
        vecs[6] = '{7'h3F, 8'hBF, 8'h3F};
        pseq = '{7'h40, 7'h60, 7'h50, 7'h58, 7'h54, 7'h56, 7'h55};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; x = '0; noise = 1'b0; glitch_en = 1'b1;
        #12;
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'hFF);
        chk("rst_uo0", uo0, 8'h00);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_conv(vecs[i].x, lat, lat0);
            chk($sformatf("vec%0d_uo", i), uo_out, vecs[i].exp_uo);
            chk($sformatf("vec%0d_uio", i), uio_out, vecs[i].exp_uio);
            chk($sformatf("vec%0d_lat", i), lat, 21);
            chk($sformatf("vec%0d_uo_s0", i), uo0, vecs[i].exp_uo);
            chk($sformatf("vec%0d_lat_s0", i), lat0, 7);
        end

        // Probe sequence for X=0x55, with the comparator inverted on non-sample edges.
        x = 7'h55;
        pulse_start();
        for (int m = 0; m < 7; m++) begin
            chk($sformatf("probe_seq%0d", m), uio_out[6:0], pseq[m]);
            noise = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            noise = 1'b0;
            @(posedge clk); #1;
        end
        chk("seq_uo", uo_out, 8'hD5);
        chk("seq_busy", uio_out[7], 1'b0);

        // Start held high: one conversion only.
        x = 7'h10;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        busy_cnt = 0;
        repeat (40) begin
            if (uio_out[7]) busy_cnt++;
            @(posedge clk); #1;
        end
        chk("held_busy_cycles", busy_cnt, 21);
        chk("held_uo", uo_out, 8'h90);
        @(negedge clk) start = 1'b0;
        repeat (2) @(posedge clk);
        x = 7'h33;
        pulse_start();
        chk("restart_done_drop", uo_out[7], 1'b0);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (uo_out[7]) begin lat = c; break; end
        end
        chk("restart_lat", lat, 21);
        chk("restart_uo", uo_out, 8'hB3);

        // Abort inside the third bit window.
        x = 7'h55;
        pulse_start();
        repeat (7) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        chk("abort_uo", uo_out, 8'h00);
        chk("abort_uio", uio_out, 8'h00);
        chk("abort_oe", uio_oe, 8'hFF);
        chk("abort_done_uo0", uo0, 8'h00);
        abort = 1'b0;
        run_conv(7'h6B, lat, lat0);
        chk("post_abort_uo", uo_out, 8'hEB);
        chk("post_abort_lat", lat, 21);

        // Asynchronous reset between edges mid-conversion.
        x = 7'h55;
        pulse_start();
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_uo", uo_out, 8'h00);
        chk("async_rst_uio", uio_out, 8'h00);
        chk("async_rst_oe", uio_oe, 8'hFF);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle_uo", uo_out, 8'h00);
        chk("post_rst_idle_uio", uio_out, 8'h00);
        run_conv(7'h01, lat, lat0);
        chk("post_rst_uo", uo_out, 8'h81);
        chk("post_rst_lat", lat, 21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/tt_um_sar_probe_ctrl.md
Name: tt_um_sar_probe_ctrl

Overview:
- Successive-approximation controller: the initiator side of the team's 8-bit less-than comparator.
- Drives a probe value B to an external comparator whose A input holds an unknown value X. Reads back the 1-bit result (X < B).
- Resolves X by binary search, MSB first, and holds X on the dedicated outputs with a done flag.
- Uses the standard Tiny Tapeout user-module port frame, so it can be wired in loop-back with the comparator on a bench or board.

Parameters:
- WIDTH, 7, bits resolved; legal range 1..7.
- SETTLE, 2, wait cycles between a probe change and sampling the comparator result; legal range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset; asynchronous assert, active low.
- ena  input  1  always 1 when powered; ignored.
- ui_in  input  8  [0] start (rising-edge triggered); [1] abort (level, synchronous); [7] cmp_lt, the comparator result (1 = X < probe); [6:2] unused.
- uo_out  output  8  [WIDTH-1:0] result; [6:WIDTH] 0; [7] done.
- uio_in  input  8  unused.
- uio_out  output  8  [WIDTH-1:0] probe value B; [6:WIDTH] 0; [7] busy.
- uio_oe  output  8  constant 8'hFF; all bidirectional pins are outputs at all times, including reset.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; result, probe, bit mask and settle counter = 0; start_d=0.
  - uo_out=0, uio_out=0.
- Start edge detect: start_rise = ui_in[0] & ~start_d. start_d is ui_in[0] registered every cycle.
- States: IDLE, WAIT, DONE.
- IDLE or DONE, start_rise=1 and abort=0:
  - result<=0; mask<=1<<(WIDTH-1); probe<=mask; cnt<=SETTLE; done<=0.
  - Next state WAIT.
- WAIT, busy=1:
  - Abort=1 -> IDLE: result<=0, probe<=0, done=0. Abort has priority over everything except reset.
  - Else if cnt!=0: cnt<=cnt-1.
  - Else (sample cycle):
    - Bit decision: if cmp_lt=0, result<=result|mask; else result unchanged.
    - If mask==1: probe<=final result; next state DONE.
    - Else: mask<=mask>>1; probe<=(next result)|(mask>>1); cnt<=SETTLE.
- DONE: done=1; result and probe held until the next start_rise.
  - Abort in DONE -> IDLE, clearing result and done.
- start_rise during WAIT is ignored; no restart.
- Start held high re-triggers nothing; exactly one conversion per rising edge.
- Latency:
  - Start edge registered at clock edge k.
  - Sample for bit i (i counted from 0 at the MSB) at edge k+(i+1)*(SETTLE+1).
  - done=1 visible after edge k+WIDTH*(SETTLE+1).
- cmp_lt is sampled only on sample cycles. Values at other times have no effect.
- Outputs are registered; no combinational path from ui_in to uo_out or uio_out.
- Reset mid-conversion: immediate return to reset values. A new start edge is required afterwards; a start pin already high at reset release counts as a rising edge.

Test Plan:
- Loop-back model cmp_lt = (X < probe), X=0x55, SETTLE=2, WIDTH=7, single-cycle start pulse at edge k:
  - probe sequence 0x40,0x60,0x50,0x58,0x54,0x56,0x55.
  - done=1 after edge k+21; uo_out=0xD5; busy=0 once done.
- Boundary values: X=0x00 -> result 0x00, every sample sees cmp_lt=1. X=0x7F -> result 0x7F, final probe 0x7F, done set.
- SETTLE=0 with a toggling cmp_lt between sample cycles, X=0x2A -> result 0x2A after exactly 7 cycles; off-sample toggles have no effect.
- Start held high for 40 cycles with X=0x10 -> exactly one conversion; done stays 1, result 0x10.
  - Dropping start and raising it again with X=0x33 -> done drops, then result 0x33.
- Abort in the 3rd bit window -> next edge: state IDLE, uo_out=0, uio_out=0, uio_oe=0xFF.
  - A subsequent start converts correctly.
- rst_n low mid-conversion (async, between edges) -> outputs 0 immediately.
  - After release with start low then a rising start, X=0x01 -> result 0x01.
